// File: rtl/test_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// test_sequencer
//
// Hardware regression loop for the MIPS core. For each programmed test it
// holds the core in reset, releases it for a cycle budget, watches the
// data-memory store bus for an expected (address, data) pair and records a
// pass bit. Scheduled interrupt pulses are driven into the core while a
// test runs.
//
// Ports
//   ph1, reset_b            clock, asynchronous active-low reset
//   start, num_tests        begin a regression of num_tests entries
//   cfg_*                   test-table write port (expected addr/data,
//                           match mask, run-cycle timeout)
//   irq_*                   interrupt-schedule write port (test, first
//                           cycle, length per channel)
//   memwrite/dataadr/
//   writedata               core store bus being observed
//   dut_reset, irq          drives into the core
//   cur_test, busy, done,
//   pass_vec, pass_count    progress and results
// ---------------------------------------------------------------------------
module test_sequencer #(
    parameter int unsigned NTESTS      = 32,
    parameter int unsigned NIRQ        = 8,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned CW          = 20,
    parameter int unsigned RSTCYC      = 6,
    parameter bit          END_ON_PASS = 1'b0,
    localparam int unsigned NW  = $clog2(NTESTS + 1),
    localparam int unsigned IW  = (NTESTS > 1) ? $clog2(NTESTS) : 1,
    localparam int unsigned CHW = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
    input  logic              ph1,
    input  logic              reset_b,
    input  logic              start,
    input  logic [NW-1:0]     num_tests,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [DW-1:0]     cfg_data,
    input  logic [1:0]        cfg_mask,
    input  logic [CW-1:0]     cfg_timeout,
    input  logic              irq_we,
    input  logic [CHW-1:0]    irq_ch,
    input  logic [IW-1:0]     irq_test,
    input  logic [CW-1:0]     irq_at,
    input  logic [CW-1:0]     irq_len,
    input  logic              memwrite,
    input  logic [AW-1:0]     dataadr,
    input  logic [DW-1:0]     writedata,
    output logic              dut_reset,
    output logic [NIRQ-1:0]   irq,
    output logic [IW-1:0]     cur_test,
    output logic              busy,
    output logic              done,
    output logic [NTESTS-1:0] pass_vec,
    output logic [NW-1:0]     pass_count
);

    localparam int unsigned RCW = (RSTCYC > 1) ? $clog2(RSTCYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_RECORD,
        ST_DONE
    } state_t;

    // Test table and interrupt schedule
    logic [AW-1:0]  exp_addr_q [NTESTS];
    logic [DW-1:0]  exp_data_q [NTESTS];
    logic [1:0]     exp_mask_q [NTESTS];
    logic [CW-1:0]  exp_tmo_q  [NTESTS];
    logic [IW-1:0]  irq_test_q [NIRQ];
    logic [CW-1:0]  irq_at_q   [NIRQ];
    logic [CW-1:0]  irq_len_q  [NIRQ];

    // Sequencer state
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RCW-1:0]    rcnt_q, rcnt_d;
    logic              hit_q, hit_d;
    logic [IW-1:0]     cur_q, cur_d;
    logic [NW-1:0]     ntests_q, ntests_d;
    logic [NTESTS-1:0] pvec_q, pvec_d;
    logic [NW-1:0]     pcnt_q, pcnt_d;

    // Registered outputs
    logic              dut_reset_q;
    logic              busy_q;
    logic              done_q;
    logic [NIRQ-1:0]   irq_q, irq_d;

    logic              cfg_open;
    logic [NW-1:0]     ntests_sat;
    logic [CW-1:0]     last_cnt;
    logic              match;

    assign cfg_open   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign ntests_sat = (32'(num_tests) > NTESTS) ? NW'(NTESTS) : num_tests;

    // Final run cycle: a zero timeout still runs for one cycle
    assign last_cnt = (exp_tmo_q[cur_q] == '0) ? '0 : exp_tmo_q[cur_q] - CW'(1);

    assign match = memwrite
                 && (!exp_mask_q[cur_q][0] || (dataadr   == exp_addr_q[cur_q]))
                 && (!exp_mask_q[cur_q][1] || (writedata == exp_data_q[cur_q]));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        hit_d    = hit_q;
        cur_d    = cur_q;
        ntests_d = ntests_q;
        pvec_d   = pvec_q;
        pcnt_d   = pcnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pvec_d   = '0;
                    pcnt_d   = '0;
                    cur_d    = '0;
                    rcnt_d   = '0;
                    ntests_d = ntests_sat;
                    state_d  = (ntests_sat == '0) ? ST_DONE : ST_RESET;
                end
            end
            ST_RESET: begin
                cnt_d = '0;
                hit_d = 1'b0;
                if (rcnt_q == RCW'(RSTCYC - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            ST_RUN: begin
                hit_d = hit_q | match;
                if ((cnt_q == last_cnt) || (END_ON_PASS && match)) begin
                    state_d = ST_RECORD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RECORD: begin
                pvec_d[cur_q] = hit_q;
                pcnt_d        = pcnt_q + NW'(hit_q);
                if (NW'(cur_q) == ntests_q - NW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    cur_d   = cur_q + IW'(1);
                    rcnt_d  = '0;
                    state_d = ST_RESET;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Interrupts are computed from the next-cycle state and counter so the
    // registered irq lines line up exactly with the RUN cycle they belong to.
    always_comb begin
        irq_d = '0;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            irq_d[i] = (state_d == ST_RUN)
                    && (cur_d == irq_test_q[i])
                    && (cnt_d >= irq_at_q[i])
                    && ({1'b0, cnt_d} < ({1'b0, irq_at_q[i]} + {1'b0, irq_len_q[i]}));
        end
    end

    always_ff @(posedge ph1 or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            hit_q       <= 1'b0;
            cur_q       <= '0;
            ntests_q    <= '0;
            pvec_q      <= '0;
            pcnt_q      <= '0;
            dut_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            irq_q       <= '0;
            for (int unsigned i = 0; i < NTESTS; i++) begin
                exp_addr_q[i] <= '0;
                exp_data_q[i] <= '0;
                exp_mask_q[i] <= '0;
                exp_tmo_q[i]  <= '0;
            end
            for (int unsigned i = 0; i < NIRQ; i++) begin
                irq_test_q[i] <= '0;
                irq_at_q[i]   <= '0;
                irq_len_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            hit_q       <= hit_d;
            cur_q       <= cur_d;
            ntests_q    <= ntests_d;
            pvec_q      <= pvec_d;
            pcnt_q      <= pcnt_d;
            dut_reset_q <= (state_d != ST_RUN);
            busy_q      <= (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_RECORD);
            done_q      <= (state_d == ST_DONE);
            irq_q       <= irq_d;
            if (cfg_open && cfg_we && (32'(cfg_idx) < NTESTS)) begin
                exp_addr_q[cfg_idx] <= cfg_addr;
                exp_data_q[cfg_idx] <= cfg_data;
                exp_mask_q[cfg_idx] <= cfg_mask;
                exp_tmo_q[cfg_idx]  <= cfg_timeout;
            end
            if (cfg_open && irq_we && (32'(irq_ch) < NIRQ)) begin
                irq_test_q[irq_ch] <= irq_test;
                irq_at_q[irq_ch]   <= irq_at;
                irq_len_q[irq_ch]  <= irq_len;
            end
        end
    end

    assign dut_reset  = dut_reset_q;
    assign irq        = irq_q;
    assign cur_test   = cur_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_vec   = pvec_q;
    assign pass_count = pcnt_q;

endmodule

// File: tb/tb_test_sequencer.sv
`timescale 1ns/1ps
module tb_test_sequencer;

    localparam int NT   = 32;
    localparam int NI   = 8;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 20;
    localparam int RST  = 6;
    localparam int NW   = $clog2(NT + 1);
    localparam int IW   = $clog2(NT);
    localparam int CHW  = $clog2(NI);
    localparam int MAXC = 1024;

    logic           ph1 = 1'b0;
    logic           reset_b = 1'b0;
    logic           start = 1'b0;
    logic [NW-1:0]  num_tests = '0;
    logic           cfg_we = 1'b0;
    logic [IW-1:0]  cfg_idx = '0;
    logic [AW-1:0]  cfg_addr = '0;
    logic [DW-1:0]  cfg_data = '0;
    logic [1:0]     cfg_mask = '0;
    logic [CW-1:0]  cfg_timeout = '0;
    logic           irq_we = 1'b0;
    logic [CHW-1:0] irq_ch = '0;
    logic [IW-1:0]  irq_test = '0;
    logic [CW-1:0]  irq_at = '0;
    logic [CW-1:0]  irq_len = '0;
    logic           memwrite = 1'b0;
    logic [AW-1:0]  dataadr = '0;
    logic [DW-1:0]  writedata = '0;

    logic           d_dut_reset, e_dut_reset;
    logic [NI-1:0]  d_irq, e_irq;
    logic [IW-1:0]  d_cur_test, e_cur_test;
    logic           d_busy, e_busy, d_done, e_done;
    logic [NT-1:0]  d_pass_vec, e_pass_vec;
    logic [NW-1:0]  d_pass_count, e_pass_count;

    test_sequencer #(.NTESTS(NT), .NIRQ(NI), .AW(AW), .DW(DW), .CW(CW),
                     .RSTCYC(RST), .END_ON_PASS(1'b0)) dut (
        .ph1(ph1), .reset_b(reset_b), .start(start), .num_tests(num_tests),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_mask(cfg_mask), .cfg_timeout(cfg_timeout),
        .irq_we(irq_we), .irq_ch(irq_ch), .irq_test(irq_test), .irq_at(irq_at), .irq_len(irq_len),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .dut_reset(d_dut_reset), .irq(d_irq), .cur_test(d_cur_test), .busy(d_busy),
        .done(d_done), .pass_vec(d_pass_vec), .pass_count(d_pass_count));

    test_sequencer #(.NTESTS(NT), .NIRQ(NI), .AW(AW), .DW(DW), .CW(CW),
                     .RSTCYC(RST), .END_ON_PASS(1'b1)) dut_e (
        .ph1(ph1), .reset_b(reset_b), .start(start), .num_tests(num_tests),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_mask(cfg_mask), .cfg_timeout(cfg_timeout),
        .irq_we(irq_we), .irq_ch(irq_ch), .irq_test(irq_test), .irq_at(irq_at), .irq_len(irq_len),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .dut_reset(e_dut_reset), .irq(e_irq), .cur_test(e_cur_test), .busy(e_busy),
        .done(e_done), .pass_vec(e_pass_vec), .pass_count(e_pass_count));

    always #5 ph1 = ~ph1;

    int total = 0;
    int bad   = 0;

    // Reference tables, store schedule (one store per test) and traces
    logic [AW-1:0] m_addr [NT];
    logic [DW-1:0] m_data [NT];
    logic [1:0]    m_mask [NT];
    int            m_tmo  [NT];
    int            i_test [NI];
    int            i_at   [NI];
    int            i_len  [NI];
    bit            s_en   [NT];
    int            s_cnt  [NT];
    logic [AW-1:0] s_addr [NT];
    logic [DW-1:0] s_data [NT];
    bit            noise;

    int            ncyc, x_total, x_pcnt, r_pcnt;
    logic [NT-1:0] x_pvec, r_pvec;
    bit            x_rst [MAXC], o_rst [MAXC];
    bit            x_busy[MAXC], o_busy[MAXC];
    bit            x_done[MAXC], o_done[MAXC];
    int            x_cur [MAXC], o_cur [MAXC];
    logic [NI-1:0] x_irq [MAXC], o_irq [MAXC];

    task automatic clear_model();
        for (int i = 0; i < NT; i++) begin
            m_addr[i] = '0; m_data[i] = '0; m_mask[i] = '0; m_tmo[i] = 0;
            s_en[i] = 1'b0; s_cnt[i] = 0; s_addr[i] = '0; s_data[i] = '0;
        end
        for (int c = 0; c < NI; c++) begin
            i_test[c] = 0; i_at[c] = 0; i_len[c] = 0;
        end
        noise = 1'b0;
    endtask

    task automatic do_reset();
        reset_b = 1'b0;
        start = 1'b0; cfg_we = 1'b0; irq_we = 1'b0; memwrite = 1'b0;
        clear_model();
        #17;
        @(posedge ph1);
        #1 reset_b = 1'b1;
    endtask

    task automatic cfg_write(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [1:0] m, input int t);
        cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_addr = a; cfg_data = d;
        cfg_mask = m; cfg_timeout = CW'(t);
        @(posedge ph1);
        #1 cfg_we = 1'b0;
        m_addr[idx] = a; m_data[idx] = d; m_mask[idx] = m; m_tmo[idx] = t;
    endtask

    task automatic irq_write(input int ch, input int tst, input int at, input int len);
        irq_we = 1'b1; irq_ch = CHW'(ch); irq_test = IW'(tst);
        irq_at = CW'(at); irq_len = CW'(len);
        @(posedge ph1);
        #1 irq_we = 1'b0;
        i_test[ch] = tst; i_at[ch] = at; i_len[ch] = len;
    endtask

    // Starts a regression and walks it cycle by cycle on the reference
    // timeline: per-test length = reset cycles + run cycles + record cycle.
    task automatic run(input int nreq, input bit early);
        int nt, ph, kk, c, off, t;
        int len[NT];
        int rl[NT];
        bit ok;
        nt = (nreq > NT) ? NT : nreq;
        x_total = 0; x_pvec = '0; x_pcnt = 0;
        for (int i = 0; i < nt; i++) begin
            t  = (m_tmo[i] == 0) ? 1 : m_tmo[i];
            ok = s_en[i] && (s_cnt[i] < t)
               && (!m_mask[i][0] || (s_addr[i] == m_addr[i]))
               && (!m_mask[i][1] || (s_data[i] == m_data[i]));
            rl[i]  = (early && ok) ? s_cnt[i] + 1 : t;
            len[i] = RST + rl[i] + 1;
            x_total += len[i];
            x_pvec[i] = ok;
            x_pcnt += int'(ok);
        end
        num_tests = NW'(nreq);
        start = 1'b1;
        @(posedge ph1);
        #1 start = 1'b0;
        ncyc = x_total + 3;
        if (ncyc > MAXC) begin
            total++; bad++;
            $display("FAIL trace_len got=%0d want<=%0d", ncyc, MAXC);
            ncyc = MAXC;
        end
        for (int n = 0; n < ncyc; n++) begin
            ph = 3; kk = (nt == 0) ? 0 : nt - 1; c = 0; off = n;
            for (int i = 0; i < nt && ph == 3; i++) begin
                if (off < len[i]) begin
                    kk = i;
                    if (off < RST) ph = 0;
                    else if (off < RST + rl[i]) begin ph = 1; c = off - RST; end
                    else ph = 2;
                end else begin
                    off -= len[i];
                end
            end
            x_rst[n] = (ph != 1); x_busy[n] = (ph < 3); x_done[n] = (ph == 3); x_cur[n] = kk;
            for (int ch = 0; ch < NI; ch++)
                x_irq[n][ch] = (ph == 1) && (i_test[ch] == kk) && (c >= i_at[ch]) && (c < i_at[ch] + i_len[ch]);
            o_rst[n]  = early ? e_dut_reset : d_dut_reset;
            o_busy[n] = early ? e_busy : d_busy;
            o_done[n] = early ? e_done : d_done;
            o_cur[n]  = int'(early ? e_cur_test : d_cur_test);
            o_irq[n]  = early ? e_irq : d_irq;
            if (ph == 1 && s_en[kk] && c == s_cnt[kk]) begin
                memwrite = 1'b1; dataadr = s_addr[kk]; writedata = s_data[kk];
            end else if ((ph == 0 || ph == 2) && noise && nt > 0) begin
                memwrite = 1'b1; dataadr = m_addr[kk]; writedata = m_data[kk];
            end else begin
                memwrite = 1'b0; dataadr = $urandom; writedata = $urandom;
            end
            @(posedge ph1);
            #1;
        end
        memwrite = 1'b0;
        r_pvec = early ? e_pass_vec : d_pass_vec;
        r_pcnt = int'(early ? e_pass_count : d_pass_count);
    endtask

    function automatic int first_done();
        for (int n = 0; n < ncyc; n++) if (o_done[n]) return n;
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        total += 7;
        if (d_dut_reset !== 1'b1) begin bad++; $display("FAIL rst_dut_reset got=%b want=1", d_dut_reset); end
        if (d_irq !== '0)         begin bad++; $display("FAIL rst_irq got=%h want=0", d_irq); end
        if (d_cur_test !== '0)    begin bad++; $display("FAIL rst_cur got=%0d want=0", d_cur_test); end
        if (d_busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", d_busy); end
        if (d_done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%b want=0", d_done); end
        if (d_pass_vec !== '0)    begin bad++; $display("FAIL rst_pvec got=%h want=0", d_pass_vec); end
        if (d_pass_count !== '0)  begin bad++; $display("FAIL rst_pcnt got=%0d want=0", d_pass_count); end
    endtask

    task automatic test_basic();
        int fd, hi;
        do_reset();
        cfg_write(0, 32'h14, 32'd21, 2'b11, 100);
        s_en[0] = 1'b1; s_cnt[0] = 40; s_addr[0] = 32'h14; s_data[0] = 32'd21;
        run(1, 1'b0);
        fd = first_done();
        hi = 0;
        while (hi < ncyc && o_rst[hi]) hi++;
        total += 4;
        if (r_pvec[0] !== 1'b1) begin bad++; $display("FAIL basic_pass got=%b want=1", r_pvec[0]); end
        if (r_pcnt != 1)        begin bad++; $display("FAIL basic_pcnt got=%0d want=1", r_pcnt); end
        if (fd != 107)          begin bad++; $display("FAIL basic_done_cycle got=%0d want=107", fd); end
        if (hi != RST)          begin bad++; $display("FAIL basic_reset_len got=%0d want=%0d", hi, RST); end
    endtask

    task automatic test_mask();
        do_reset();
        cfg_write(0, 32'h204, 32'd0, 2'b01, 100);
        s_en[0] = 1'b1; s_cnt[0] = 12; s_addr[0] = 32'h204; s_data[0] = 32'd99;
        run(1, 1'b0);
        total += 2;
        if (r_pvec[0] !== 1'b1) begin bad++; $display("FAIL mask01_pass got=%b want=1", r_pvec[0]); end
        cfg_write(0, 32'h204, 32'd7, 2'b11, 100);
        if (d_pass_vec[0] !== 1'b1) begin bad++; $display("FAIL done_write_keeps got=%b want=1", d_pass_vec[0]); end
        run(1, 1'b0);
        total += 2;
        if (r_pvec[0] !== 1'b0) begin bad++; $display("FAIL mask11_fail got=%b want=0", r_pvec[0]); end
        if (r_pcnt != 0)        begin bad++; $display("FAIL mask11_pcnt got=%0d want=0", r_pcnt); end
    endtask

    task automatic test_last_cycle();
        int fd;
        do_reset();
        cfg_write(0, 32'h40, 32'h5, 2'b11, 20);
        cfg_write(1, 32'h44, 32'h6, 2'b00, 0);
        cfg_write(2, 32'h48, 32'h7, 2'b11, 20);
        s_en[0] = 1'b1; s_cnt[0] = 19; s_addr[0] = 32'h40; s_data[0] = 32'h5;
        s_en[1] = 1'b1; s_cnt[1] = 0;  s_addr[1] = 32'h99; s_data[1] = 32'h1;
        s_en[2] = 1'b1; s_cnt[2] = 20; s_addr[2] = 32'h48; s_data[2] = 32'h7;
        noise = 1'b1;
        run(3, 1'b0);
        fd = first_done();
        total += 3;
        if (r_pvec[2:0] !== 3'b011) begin bad++; $display("FAIL last_cycle_pvec got=%b want=011", r_pvec[2:0]); end
        if (r_pcnt != 2)            begin bad++; $display("FAIL last_cycle_pcnt got=%0d want=2", r_pcnt); end
        if (fd != 27 + 8 + 27)      begin bad++; $display("FAIL last_cycle_done got=%0d want=62", fd); end
    endtask

    task automatic test_early();
        int fd;
        do_reset();
        cfg_write(0, 32'h80, 32'h33, 2'b11, 1000);
        s_en[0] = 1'b1; s_cnt[0] = 10; s_addr[0] = 32'h80; s_data[0] = 32'h33;
        run(1, 1'b1);
        fd = first_done();
        total += 2;
        if (fd != 18)        begin bad++; $display("FAIL early_len got=%0d want=18", fd); end
        if (r_pvec[0] !== 1) begin bad++; $display("FAIL early_pass got=%b want=1", r_pvec[0]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) cfg_write(i, 32'h100 + 32'(i), 32'h200 + 32'(i), 2'b11, 30);
        s_en[0] = 1'b1; s_cnt[0] = 5;  s_addr[0] = 32'h100; s_data[0] = 32'h200;
        s_en[2] = 1'b1; s_cnt[2] = 29; s_addr[2] = 32'h102; s_data[2] = 32'h202;
        run(3, 1'b0);
        total += 5;
        if (r_pvec[2:0] !== 3'b101) begin bad++; $display("FAIL b2b_pvec got=%b want=101", r_pvec[2:0]); end
        if (r_pcnt != 2)            begin bad++; $display("FAIL b2b_pcnt got=%0d want=2", r_pcnt); end
        if (o_cur[0] != 0)          begin bad++; $display("FAIL b2b_cur0 got=%0d want=0", o_cur[0]); end
        if (o_cur[37] != 1)         begin bad++; $display("FAIL b2b_cur1 got=%0d want=1", o_cur[37]); end
        if (o_cur[74] != 2)         begin bad++; $display("FAIL b2b_cur2 got=%0d want=2", o_cur[74]); end
    endtask

    task automatic test_irq();
        int hi;
        do_reset();
        for (int i = 0; i < 3; i++) cfg_write(i, '0, '0, 2'b00, 80);
        irq_write(1, 1, 50, 5);
        irq_write(0, 1, 0, 0);
        run(3, 1'b0);
        hi = 0;
        for (int n = 0; n < ncyc; n++) begin
            hi += int'(o_irq[n][1]);
            total++;
            if (o_irq[n] !== x_irq[n]) begin bad++; $display("FAIL irq_trace n=%0d got=%h want=%h", n, o_irq[n], x_irq[n]); end
        end
        total++;
        if (hi != 5) begin bad++; $display("FAIL irq1_cycles got=%0d want=5", hi); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < NT; i++) begin s_en[i] = 1'b1; s_cnt[i] = 0; s_addr[i] = $urandom; end
        run(40, 1'b0);
        total += 2;
        if (r_pcnt != NT)         begin bad++; $display("FAIL sat_pcnt got=%0d want=%0d", r_pcnt, NT); end
        if (first_done() != 256)  begin bad++; $display("FAIL sat_done got=%0d want=256", first_done()); end
    endtask

    task automatic test_midrun_reset();
        do_reset();
        for (int i = 0; i < 3; i++) cfg_write(i, 32'h10, 32'h20, 2'b00, 30);
        irq_write(2, 2, 0, 100);
        memwrite = 1'b1;
        num_tests = NW'(3);
        start = 1'b1;
        @(posedge ph1);
        #1 start = 1'b0;
        repeat (83) @(posedge ph1);
        #1;
        total += 3;
        if (d_irq[2] !== 1'b1)  begin bad++; $display("FAIL pre_irq got=%b want=1", d_irq[2]); end
        if (d_cur_test !== 2)   begin bad++; $display("FAIL pre_cur got=%0d want=2", d_cur_test); end
        if (d_pass_count !== 2) begin bad++; $display("FAIL pre_pcnt got=%0d want=2", d_pass_count); end
        #2 reset_b = 1'b0;
        #1;
        total += 6;
        if (d_dut_reset !== 1'b1) begin bad++; $display("FAIL abort_dut_reset got=%b want=1", d_dut_reset); end
        if (d_irq !== '0)         begin bad++; $display("FAIL abort_irq got=%h want=0", d_irq); end
        if (d_cur_test !== '0)    begin bad++; $display("FAIL abort_cur got=%0d want=0", d_cur_test); end
        if (d_busy !== 1'b0)      begin bad++; $display("FAIL abort_busy got=%b want=0", d_busy); end
        if (d_pass_vec !== '0)    begin bad++; $display("FAIL abort_pvec got=%h want=0", d_pass_vec); end
        if (d_pass_count !== '0)  begin bad++; $display("FAIL abort_pcnt got=%0d want=0", d_pass_count); end
        memwrite = 1'b0;
        clear_model();
        @(posedge ph1);
        #1 reset_b = 1'b1;
        run(0, 1'b0);
        total += 2;
        if (o_done[0] !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", o_done[0]); end
        if (r_pcnt != 0)        begin bad++; $display("FAIL zero_pcnt got=%0d want=0", r_pcnt); end
        // Table was cleared by reset: mask 00 and timeout 0 means one run cycle, any store passes
        s_en[0] = 1'b1; s_cnt[0] = 0; s_addr[0] = $urandom; s_data[0] = $urandom;
        run(1, 1'b0);
        total += 2;
        if (r_pvec[0] !== 1'b1)  begin bad++; $display("FAIL cleared_pass got=%b want=1", r_pvec[0]); end
        if (first_done() != 8)   begin bad++; $display("FAIL cleared_len got=%0d want=8", first_done()); end
    endtask

    task automatic test_random();
        int nt;
        bit early;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            nt = $urandom_range(1, 5);
            early = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            for (int i = 0; i < nt; i++) begin
                a = $urandom_range(0, 255);
                d = $urandom;
                cfg_write(i, a, d, 2'($urandom_range(0, 3)), $urandom_range(0, 30));
                s_en[i]   = ($urandom_range(0, 3) != 0);
                s_cnt[i]  = $urandom_range(0, 35);
                s_addr[i] = $urandom_range(0, 1) ? a : AW'($urandom_range(0, 255));
                s_data[i] = $urandom_range(0, 1) ? d : DW'($urandom);
            end
            for (int ch = 0; ch < 4; ch++)
                irq_write(ch, $urandom_range(0, nt - 1), $urandom_range(0, 30), $urandom_range(0, 10));
            run(nt, early);
            for (int n = 0; n < ncyc; n++) begin
                total += 5;
                if (o_rst[n] !== x_rst[n])   begin bad++; $display("FAIL rnd_dut_reset it=%0d n=%0d got=%b want=%b", it, n, o_rst[n], x_rst[n]); end
                if (o_busy[n] !== x_busy[n]) begin bad++; $display("FAIL rnd_busy it=%0d n=%0d got=%b want=%b", it, n, o_busy[n], x_busy[n]); end
                if (o_done[n] !== x_done[n]) begin bad++; $display("FAIL rnd_done it=%0d n=%0d got=%b want=%b", it, n, o_done[n], x_done[n]); end
                if (o_cur[n] != x_cur[n])    begin bad++; $display("FAIL rnd_cur it=%0d n=%0d got=%0d want=%0d", it, n, o_cur[n], x_cur[n]); end
                if (o_irq[n] !== x_irq[n])   begin bad++; $display("FAIL rnd_irq it=%0d n=%0d got=%h want=%h", it, n, o_irq[n], x_irq[n]); end
            end
            total += 2;
            if (r_pvec !== x_pvec) begin bad++; $display("FAIL rnd_pvec it=%0d got=%h want=%h", it, r_pvec, x_pvec); end
            if (r_pcnt != x_pcnt)  begin bad++; $display("FAIL rnd_pcnt it=%0d got=%0d want=%0d", it, r_pcnt, x_pcnt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_last_cycle();
        test_early();
        test_back_to_back();
        test_irq();
        test_saturate();
        test_midrun_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/test_sequencer.md
# test_sequencer

Synthesizable, parametrised test-run sequencer that automates the core regression loop in hardware: it holds the MIPS core in reset, releases it for a programmed cycle budget, and watches the data-memory write bus for a per-test expected (address, data) pair. It also drives scheduled interrupt pulses into the core and records pass/fail per test. It sits between `top` and an FPGA/emulation host, replacing the behavioural testbench loop, and supports N tests, N interrupt lines, configurable match masks and early exit.

## Interface
- `NTESTS`, 32, number of test-table entries.
- `NIRQ`, 8, interrupt channels driven into the core.
- `AW`, 32, data-address width.
- `DW`, 32, write-data width.
- `CW`, 20, run-cycle counter / timeout width.
- `RSTCYC`, 6, cycles `dut_reset` is held before each test (≥1).
- `END_ON_PASS`, 0, if 1 a test ends on its first match instead of at timeout.

- `ph1` in 1 clock; all state updates on rising edge.
- `reset_b` in 1 asynchronous, active-low reset.
- `start` in 1 begin a regression (honoured in IDLE/DONE only).
- `num_tests` in clog2(NTESTS+1) tests to run; latched on start.
- `cfg_we` in 1 test-table write strobe (honoured in IDLE/DONE only).
- `cfg_idx` in clog2(NTESTS) table entry written.
- `cfg_addr` in AW expected address.
- `cfg_data` in DW expected data.
- `cfg_mask` in 2 bit0 = check address, bit1 = check data.
- `cfg_timeout` in CW run cycles for the entry.
- `irq_we` in 1 interrupt-schedule write strobe (IDLE/DONE only).
- `irq_ch` in clog2(NIRQ) channel written.
- `irq_test` in clog2(NTESTS) test in which the channel pulses.
- `irq_at` in CW run-counter value of first asserted cycle.
- `irq_len` in CW pulse length in cycles (0 = channel disabled).
- `memwrite` in 1 core store strobe.
- `dataadr` in AW core store address.
- `writedata` in DW core store data.
- `dut_reset` out 1 active-high reset to `top`.
- `irq` out NIRQ interrupts to `top`.
- `cur_test` out clog2(NTESTS) index of test in progress.
- `busy` out 1 high in RESET/RUN/RECORD.
- `done` out 1 high in DONE.
- `pass_vec` out NTESTS per-test pass bits.
- `pass_count` out clog2(NTESTS+1) number of passed tests.

## Operation
- States: IDLE, RESET, RUN, RECORD, DONE.
- IDLE: `start` → clear `pass_vec`, `pass_count`, `cur_test`, latch `num_tests`; go to RESET, or directly to DONE if `num_tests`=0.
- RESET: `dut_reset`=1 for exactly RSTCYC cycles, then RUN; run counter `cnt` cleared, sticky `hit` cleared.
- RUN: `dut_reset`=0; `cnt` increments each cycle from 0. Effective timeout T = max(`cfg_timeout`,1). Exit to RECORD after cycle with `cnt`=T-1, or (END_ON_PASS=1) after the first cycle with a match.
- Match: `memwrite` & (!mask[0] | `dataadr`==exp_addr) & (!mask[1] | `writedata`==exp_data), comparisons using `===`-free exact equality on full width. Mask 00 = any store passes. `hit` is sticky.
- RECORD (1 cycle, `dut_reset`=1): `pass_vec[cur_test]`<=`hit`; `pass_count`+=`hit`; if `cur_test`==num_tests-1 → DONE, else `cur_test`+1 → RESET.
- DONE: `dut_reset`=1, outputs held; `start` restarts as from IDLE.
- Interrupts: `irq[ch]`=1 exactly during RUN cycles where `cur_test`==irq_test[ch] and irq_at ≤ `cnt` < irq_at+irq_len (sum computed CW+1 bits, no wrap). `irq` is registered (glitch-free) and forced 0 outside RUN.
- `num_tests` > NTESTS saturates to NTESTS.
- Config/schedule writes and `start` while `busy` are ignored; writing in DONE does not clear results.

## Timing
- Reset (`reset_b`=0, any time, async): state IDLE, `dut_reset`=1, `irq`=0, `cur_test`=0, `busy`=0, `done`=0, `pass_vec`=0, `pass_count`=0, table and schedule cleared (mask 00, timeout 0, irq_len 0). Mid-run reset aborts with no partial record.
- `start` sampled at edge 0 → `busy`=1 and RESET from edge 1.
- Cycles per test without early exit: RSTCYC + T + 1.
- Match on the last RUN cycle counts; `memwrite` during RESET/RECORD is ignored.
- `done` rises on the edge after the final RECORD.

## Test plan
- Entry 0: addr 0x14, data 21, mask 11, timeout 100; drive store (0x14,21) at cnt 40 → `pass_vec[0]`=1, `pass_count`=1, `done` after 6+100+1 cycles.
- Entry 0 mask 01 addr 0x204; store (0x204,99) → pass; mask 11 data 7 same store → fail, `pass_count`=0.
- END_ON_PASS=1, timeout 1000, match at cnt 10 → RECORD next cycle, test length 6+11+1 cycles.
- `num_tests`=3, tests 0 and 2 match, 1 never stores → `pass_vec`=3'b101, `pass_count`=2, `cur_test` sequence 0,1,2.
- irq ch1: test 1, at 50, len 5 → `irq[1]` high exactly cnt 50–54 of test 1 only; ch0 len 0 never asserts.
- Assert `reset_b` low during RUN of test 2 → all outputs to reset values immediately; `start` with `num_tests`=0 → DONE next edge, `pass_count`=0.
